// File: rtl/logic_equiv_pkg.sv
// ============================================================================
// Module   : logic_equiv_pkg
// Purpose  : Shared scanner state encoding and legal parameter bounds.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package logic_equiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } scan_state_t;

  localparam int c_n_min = 1;
  localparam int c_n_max = 16;
  localparam int c_m_min = 1;
  localparam int c_m_max = 32;

endpackage

`default_nettype wire

// File: rtl/logic_equiv_scan_counter.sv
// ============================================================================
// Module   : scan_counter
// Purpose  : N-bit stimulus up-counter with clear, enable and all-ones flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  // Incrementing past all-ones wraps to zero, which is the idle vector.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = &r_count;

endmodule

`default_nettype wire

// File: rtl/logic_equiv_scanner.sv
// ============================================================================
// Module   : logic_equiv_scanner
// Purpose  : Exhaustive equivalence scan of two combinational implementations.
//            Optional macro STOP_ON_FAIL_EN ends the scan at the first mismatch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_equiv_scanner
  import logic_equiv_pkg::*;
#(
  parameter int N = 2,
  parameter int M = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic [N-1:0] vec_o,
  input  logic [M-1:0] resp_a,
  input  logic [M-1:0] resp_b,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic         first_fail_valid,
  output logic [N-1:0] first_fail_vec
);

  if (N < c_n_min || N > c_n_max || M < c_m_min || M > c_m_max) begin : g_param_check
    $error("logic_equiv_scanner: N or M outside the supported range");
  end

  scan_state_t  r_state;
  logic         r_busy;
  logic         r_done;
  logic         r_pass;
  logic [N:0]   r_err_count;
  logic         r_ff_valid;
  logic [N-1:0] r_ff_vec;

  logic [N-1:0] w_vec;
  logic         w_tc;
  logic         w_scan;
  logic         w_mismatch;
  logic         w_stop;
  logic         w_finish;
  logic [N:0]   w_err_next;

  assign w_scan     = (r_state == S_SCAN);
  assign w_mismatch = (resp_a != resp_b);
  assign w_err_next = r_err_count + {{N{1'b0}}, w_mismatch};

`ifdef STOP_ON_FAIL_EN
  assign w_stop = w_scan && w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  assign w_finish = w_scan && (w_tc || w_stop);

  // An early stop clears the counter so DONE presents the idle vector.
  scan_counter #(
    .W (N)
  ) u_counter (
    .clk     (clk),
    .rst     (reset),
    .i_clr   (w_stop),
    .i_en    (w_scan),
    .o_count (w_vec),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= '0;
      r_ff_valid  <= 1'b0;
      r_ff_vec    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state     <= S_SCAN;
            r_busy      <= 1'b1;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_ff_valid  <= 1'b0;
            r_ff_vec    <= '0;
          end
        end
        S_SCAN: begin
          if (w_mismatch) begin
            r_err_count <= w_err_next;
            if (!r_ff_valid) begin
              r_ff_valid <= 1'b1;
              r_ff_vec   <= w_vec;
            end
          end
          // The verdict includes the vector compared on this same edge.
          if (w_finish) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign vec_o            = w_vec;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_err_count;
  assign first_fail_valid = r_ff_valid;
  assign first_fail_vec   = r_ff_vec;

endmodule

`default_nettype wire

// File: doc/logic_equiv_scanner.md
# logic_equiv_scanner

Parametrised, clocked exhaustive-equivalence scanner for small combinational functions. It drives all 2^N input vectors, one per clock, into two externally instantiated implementations of the same function, such as a NOR-only gate netlist and its expression form. It compares their responses cycle by cycle and reports a mismatch count, the first failing vector and a pass/fail verdict. It replaces the hand-written per-vector `$monitor` benches used for the gate-equivalence exercises and is synthesisable, so it can run on the board.

## Interface
Parameters:
- `N`, default 2: number of function inputs; legal range 1..16.
- `M`, default 1: response width of each implementation; legal range 1..32.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: begin a scan; sampled only in IDLE.
- `vec_o` output N: stimulus vector driven to both implementations.
- `resp_a` input M: response of implementation A to `vec_o`; combinational.
- `resp_b` input M: response of implementation B to `vec_o`; combinational.
- `busy` output 1: high in SCAN and DONE.
- `done` output 1: one-cycle pulse in DONE.
- `pass` output 1: verdict of the last completed scan; held until the next `start`.
- `err_count` output N+1: number of mismatching vectors in the last or current scan.
- `first_fail_valid` output 1: a mismatch has been captured.
- `first_fail_vec` output N: vector of the first mismatch.

## Operation
- FSM states: S_IDLE, S_SCAN, S_DONE.
- **S_IDLE:** `vec_o` = 0.
  - `start`=1 moves to S_SCAN.
  - On the same edge, clear `err_count`, `first_fail_valid`, `first_fail_vec` and `pass`.
- **S_SCAN:** every edge compares `resp_a != resp_b` for the current `vec_o`.
  - On a mismatch, `err_count` += 1.
  - If `first_fail_valid`=0, capture `first_fail_vec` = `vec_o` and set `first_fail_valid`.
  - Then `vec_o` += 1.
  - When `vec_o` == 2^N−1 has been compared, go to S_DONE and wrap `vec_o` to 0. There is no further increment.
- **S_DONE:** `done`=1 for exactly one cycle. `pass` = (`err_count`==0), including the final vector's result. Next state is S_IDLE.
- `start` is ignored while `busy`=1. There is no queuing.
- `err_count` is N+1 bits wide and holds 2^N exactly, so no saturation is needed.
- Reset at any point, including mid-scan, forces S_IDLE and all outputs to their reset values. A partial scan is discarded.

## Timing
- Reset values: `vec_o`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail_valid`=0, `first_fail_vec`=0.
- `start` sampled at edge E0. SCAN runs from E0 to E0+2^N, covering 2^N cycles with vector k present during cycle k.
- `done` is high during the cycle after edge E0+2^N. `busy` falls after E0+2^N+1.
- Total latency from `start` to `done` is 2^N+1 cycles.
- `resp_a`/`resp_b` must settle within the same cycle as `vec_o`. No pipelined implementations are supported.
- `start` held high continuously: a new scan begins on the first edge in S_IDLE, giving back-to-back scans with one idle cycle between them.

## Configuration
- **`STOP_ON_FAIL_EN` defined:** the first mismatch in S_SCAN goes directly to S_DONE on that edge.
  - `err_count`=1, `pass`=0, `first_fail_vec` valid.
  - `done` follows one cycle after the failing compare.
- **Not defined:** the full 2^N scan always runs and `err_count` totals all mismatches.

## Structure
- Package `logic_equiv_pkg` holds:
  - the state typedef `scan_state_t` (S_IDLE=2'd0, S_SCAN=2'd1, S_DONE=2'd2);
  - localparams for the legal N/M bounds.
- One sub-module `scan_counter`: N-bit up-counter with clear, enable and a terminal-count flag (`vec_o` == all ones). The top holds the FSM, comparator and capture registers.
- Stimulus bit mapping: `vec_o[N-1]` is the most significant input. With N=2, `vec_o`={a,b}.

## Test plan
- **Identical implementations.** N=2, M=1, both ports driven by a&~b, `start` pulsed → `vec_o` steps 00,01,10,11 → `done` 5 cycles after `start`, `pass`=1, `err_count`=0, `first_fail_valid`=0.
- **Differing implementations.** N=2, M=1, A=a&~b (NOR form), B=~a&b → mismatches at 01 and 10 → `err_count`=2, `first_fail_vec`=2'b01, `pass`=0.
- **Wide single fault.** N=4, M=2, B differs from A only at vector 4'hF → `err_count`=1, `first_fail_vec`=4'hF, `done` 17 cycles after `start`.
- **Early stop.** Same as the differing-implementations case, built with `STOP_ON_FAIL_EN` → `done` 3 cycles after `start`, `err_count`=1, `first_fail_vec`=2'b01.
- **Reset mid-scan.** `reset` asserted at the 2nd SCAN cycle → next cycle all outputs are at reset values and `busy`=0. A following `start` completes a normal scan.
- **Start ignored while busy.** `start` re-pulsed while `busy`=1 → ignored, exactly one `done` pulse, counts unchanged from a single scan.
